muldiv_sequencer: RTL and testbench

Multi-cycle controller for the integer multiply/divide resource alongside the EX-stage ALU. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from EX and runs them iteratively over one shared 33-bit add/subtract step. It owns the HI/LO architectural registers and raises `stall` so that MFHI, MFLO or a second mul/div waits for an in-flight operation.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_step.sv | 48 ++++
 rtl/muldiv_sequencer.sv | 167 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the multiply/divide sequencer: the funct codes it
//   decodes, the sequencer state enum and small decode helpers.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } state_t;

  // True for the four iterative operations.
  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  // True for every instruction that touches HI/LO and must wait while busy.
  function automatic logic is_hilo_op(input logic [5:0] funct);
    return is_muldiv(funct) ||
           (funct == FUNCT_MTHI) || (funct == FUNCT_MTLO) ||
           (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if
//   Bundle between the EX stage (master) and the mul/div sequencer (slave).
//   master drives: start, funct, op_a, op_b, abort
//   slave drives : busy, stall, done, hi, lo
interface muldiv_if #(
  parameter int DATA_W = 32
) ();
  logic              start;
  logic [5:0]        funct;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              abort;
  logic              busy;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, funct, op_a, op_b, abort,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, funct, op_a, op_b, abort,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step
//   One iteration of the shared (DATA_W+1)-bit add/subtract datapath.
//   Ports:
//     is_div  - 1: restoring-divide step, 0: shift-add multiply step
//     acc_hi  - upper accumulator half (partial product / partial remainder)
//     acc_lo  - lower accumulator half (multiplier bits / dividend-quotient)
//     operand - multiplicand or divisor magnitude
//     next_hi, next_lo - accumulator after this iteration
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] next_hi,
  output logic [DATA_W-1:0] next_lo
);

  logic [DATA_W:0]   opa;
  logic [DATA_W:0]   opb;
  logic [DATA_W+1:0] sum;
  logic              no_borrow;

  // Divide subtracts via opa + ~opb + 1; the extra top bit is the carry-out,
  // set exactly when the shifted remainder is >= the divisor.
  always_comb begin
    if (is_div) begin
      opa = {acc_hi, acc_lo[DATA_W-1]};
      opb = {1'b0, operand};
      sum = {1'b0, opa} + {1'b0, ~opb} + {{(DATA_W+1){1'b0}}, 1'b1};
    end else begin
      opa = {1'b0, acc_hi};
      opb = acc_lo[0] ? {1'b0, operand} : '0;
      sum = {1'b0, opa} + {1'b0, opb};
    end
    no_borrow = sum[DATA_W+1];

    if (is_div) begin
      next_hi = no_borrow ? sum[DATA_W-1:0] : opa[DATA_W-1:0];
      next_lo = {acc_lo[DATA_W-2:0], no_borrow};
    end else begin
      next_hi = sum[DATA_W:1];
      next_lo = {sum[0], acc_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle controller for MULT/MULTU/DIV/DIVU plus MTHI/MTLO. Owns the
//   HI/LO registers and stalls EX while an operation is in flight.
//   Ports:
//     clk     - rising-edge clock
//     reset_n - asynchronous active-low reset
//     bus     - muldiv_if slave: start/funct/op_a/op_b/abort in,
//               busy/stall/done/hi/lo out
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     reset_n,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] opnd;
  logic              op_div;
  logic              op_signed;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              div_sel;
  logic              sgn_sel;
  logic [DATA_W-1:0] step_hi;
  logic [DATA_W-1:0] step_lo;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] fix_hi;
  logic [DATA_W-1:0] fix_lo;
  logic              busy;
  logic              done;
  logic              stall;

  assign div_sel = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
  assign sgn_sel = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div  (op_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (opnd),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // abort pulls PREP/RUN/FIX back to IDLE; IDLE and DONE ignore it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start && is_muldiv(bus.funct)) next_state = PREP;
      PREP: next_state = bus.abort ? IDLE : RUN;
      RUN:  begin
        if (bus.abort)             next_state = IDLE;
        else if (cnt == CNT_LAST)  next_state = FIX;
      end
      FIX:  next_state = bus.abort ? IDLE : DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    stall = busy && bus.start && is_hilo_op(bus.funct);
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.stall = stall;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Sign fix-up of the unsigned magnitude result. A zero divisor forces an
  // all-ones quotient; the remainder path already yields the original op_a.
  always_comb begin
    product = {acc_hi, acc_lo};
    if (neg_q) product = -product;
    quot = neg_q ? -acc_lo : acc_lo;
    rem  = neg_r ? -acc_hi : acc_hi;
    if (op_div) begin
      fix_hi = rem;
      fix_lo = div_zero ? '1 : quot;
    end else begin
      fix_hi = product[2*DATA_W-1:DATA_W];
      fix_lo = product[DATA_W-1:0];
    end
  end

  // Multiply keeps the multiplier in acc_lo and multiplicand in opnd;
  // divide keeps the dividend in acc_lo and divisor in opnd.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_muldiv(bus.funct)) begin
              op_div    <= div_sel;
              op_signed <= sgn_sel;
              acc_hi    <= '0;
              acc_lo    <= div_sel ? bus.op_a : bus.op_b;
              opnd      <= div_sel ? bus.op_b : bus.op_a;
              div_zero  <= div_sel && (bus.op_b == '0);
              cnt       <= '0;
            end else if (bus.funct == FUNCT_MTHI) begin
              hi_q <= bus.op_a;
            end else if (bus.funct == FUNCT_MTLO) begin
              lo_q <= bus.op_a;
            end
          end
        end
        PREP: begin
          neg_q  <= op_signed && (acc_lo[DATA_W-1] ^ opnd[DATA_W-1]);
          neg_r  <= op_signed && op_div && acc_lo[DATA_W-1];
          acc_lo <= (op_signed && acc_lo[DATA_W-1]) ? -acc_lo : acc_lo;
          opnd   <= (op_signed && opnd[DATA_W-1])   ? -opnd   : opnd;
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (!bus.abort) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer. Inputs are driven and outputs are
//   sampled on the falling clock edge; "cycle k" is the interval after the
//   k-th rising edge counted from the accepting edge E0 (cycle 1 = PREP).
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   compared   = 0;
  int   mismatched = 0;

  muldiv_if #(.DATA_W(DATA_W)) bus ();

  muldiv_sequencer #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic st, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic ab);
    bus.start = st;
    bus.funct = fn;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.abort = ab;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic runOp(input string tag, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    applyStimulus(1'b1, fn, a, b, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    checkOutput({tag, " busy@1"}, 32'(bus.busy), 32'd1);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      nextCycle();
      cyc++;
    end
    checkOutput({tag, " done cycle"}, 32'(cyc), 32'd35);
    checkOutput({tag, " hi"}, bus.hi, exp_hi);
    checkOutput({tag, " lo"}, bus.lo, exp_lo);
    checkOutput({tag, " busy@35"}, 32'(bus.busy), 32'd1);
    nextCycle();
    checkOutput({tag, " busy@36"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " done@36"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int done_seen;

    // Reset state, with an MFHI presented to show stall is masked.
    reset_n = 1'b0;
    applyStimulus(1'b1, FUNCT_MFHI, 32'd0, 32'd0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset stall", 32'(bus.stall), 32'd0);
    checkOutput("reset hi", bus.hi, 32'd0);
    checkOutput("reset lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    nextCycle();

    // MTLO in IDLE: one-edge write, no busy.
    applyStimulus(1'b1, FUNCT_MTLO, 32'h0000_1234, 32'd0, 1'b0);
    checkOutput("mtlo stall", 32'(bus.stall), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("mtlo lo", bus.lo, 32'h0000_1234);
    checkOutput("mtlo busy", 32'(bus.busy), 32'd0);
    checkOutput("mtlo done", 32'(bus.done), 32'd0);

    // Arithmetic vectors.
    runOp("multu max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("mult -3*7", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runOp("mult min*min", FUNCT_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    runOp("multu shift", FUNCT_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
    runOp("div -7/2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div min/-1", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    runOp("divu 7/2", FUNCT_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    runOp("div -5/0", FUNCT_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    runOp("divu 5/0", FUNCT_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

    // MULT -1*1 with an MFHI presented from cycle 5 until it is released.
    applyStimulus(1'b1, FUNCT_MULT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    repeat (4) nextCycle();
    applyStimulus(1'b1, FUNCT_MFHI, 32'd0, 32'd0, 1'b0);
    for (int k = 5; k <= 35; k++) begin
      checkOutput($sformatf("stall c%0d", k), 32'(bus.stall), 32'd1);
      if (k == 35) checkOutput("stall done c35", 32'(bus.done), 32'd1);
      nextCycle();
    end
    checkOutput("stall c36", 32'(bus.stall), 32'd0);
    checkOutput("stall hi c36", bus.hi, 32'hFFFF_FFFF);
    checkOutput("stall lo c36", bus.lo, 32'hFFFF_FFFF);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("mfhi no effect", 32'(bus.busy), 32'd0);

    // Reset in the middle of RUN clears everything immediately.
    applyStimulus(1'b1, FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    repeat (9) nextCycle();
    checkOutput("pre-reset busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset hi", bus.hi, 32'd0);
    checkOutput("midreset lo", bus.lo, 32'd0);
    nextCycle();
    reset_n = 1'b1;
    nextCycle();

    // abort during RUN keeps HI/LO and suppresses done.
    applyStimulus(1'b1, FUNCT_MTHI, 32'h0000_AAAA, 32'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, FUNCT_MTLO, 32'h0000_5555, 32'd0, 1'b0);
    nextCycle();
    checkOutput("mthi hi", bus.hi, 32'h0000_AAAA);
    checkOutput("mtlo2 lo", bus.lo, 32'h0000_5555);
    applyStimulus(1'b1, FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    repeat (19) nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("abort busy before", 32'(bus.busy), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("abort busy after", 32'(bus.busy), 32'd0);
    checkOutput("abort hi", bus.hi, 32'h0000_AAAA);
    checkOutput("abort lo", bus.lo, 32'h0000_5555);
    done_seen = 0;
    repeat (40) begin
      nextCycle();
      if (bus.done === 1'b1) done_seen++;
    end
    checkOutput("abort done pulses", 32'(done_seen), 32'd0);

    // abort in FIX wins over the result write.
    applyStimulus(1'b1, FUNCT_DIVU, 32'd7, 32'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    repeat (33) nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("fix abort busy", 32'(bus.busy), 32'd0);
    checkOutput("fix abort done", 32'(bus.done), 32'd0);
    checkOutput("fix abort hi", bus.hi, 32'h0000_AAAA);
    checkOutput("fix abort lo", bus.lo, 32'h0000_5555);

    // abort in IDLE does not block an MTLO.
    applyStimulus(1'b1, FUNCT_MTLO, 32'h0000_0077, 32'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("idle abort mtlo", bus.lo, 32'h0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
